// File: rtl/bcd_seq_add_ctrl_if.sv
// Handshake and operand/result bus for the sequential BCD adder.
// The slave side is the adder; the master side is the producer/consumer.
interface bcd_seq_add_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [4*NUM_DIGITS-1:0]   a_i;
  logic [4*NUM_DIGITS-1:0]   b_i;
  logic                      cin_i;
  logic                      out_valid;
  logic                      out_ready;
  logic [4*NUM_DIGITS-1:0]   sum_o;
  logic                      cout_o;
  logic                      err_o;
  logic                      busy_o;

  modport master (
    output in_valid, a_i, b_i, cin_i, out_ready,
    input  in_ready, out_valid, sum_o, cout_o, err_o, busy_o
  );

  modport slave (
    input  in_valid, a_i, b_i, cin_i, out_ready,
    output in_ready, out_valid, sum_o, cout_o, err_o, busy_o
  );
endinterface

// File: rtl/bcd_seq_add_ctrl.sv
// Sequential BCD adder: one 2-digit BCD stage processes a digit pair per
// RUN cycle, rippling the decimal carry through a register. Operands with
// any nibble above 9 are rejected straight to DONE with err_o set.
module bcd_seq_add_ctrl #(
  parameter int NUM_DIGITS = 8
) (
  input logic               clk,
  input logic               rst_n,
  bcd_seq_add_ctrl_if.slave bus
);
  localparam int W     = 4 * NUM_DIGITS;
  localparam int PAIRS = NUM_DIGITS / 2;
  localparam int IW    = $clog2(PAIRS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic           ready_q;
  logic [W-1:0]   a_q, b_q, sum_q;
  logic           carry_q, cout_q, err_q;
  logic [IW-1:0]  idx_q;

  logic           accept, bad_digit, last_pair;
  logic [4:0]     lo_raw, hi_raw, lo_adj, hi_adj;
  logic           lo_c;
  logic [7:0]     slice_sum;
  logic           slice_cout;

  assign accept    = bus.in_valid && ready_q && (state == IDLE);
  assign last_pair = (idx_q == IW'(PAIRS - 1));

  // Flag any operand nibble outside 0..9 at the accept point.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bus.a_i[4*i +: 4] > 4'd9 || bus.b_i[4*i +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end

  // The single 2-digit BCD stage, fed by the low pair of the shifting operands.
  always_comb begin
    lo_raw = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'd0, carry_q};
    lo_adj = lo_raw + 5'd6;
    slice_sum = '0;
    if (lo_raw > 5'd9) begin
      slice_sum[3:0] = lo_adj[3:0];
      lo_c           = 1'b1;
    end else begin
      slice_sum[3:0] = lo_raw[3:0];
      lo_c           = 1'b0;
    end
    hi_raw = {1'b0, a_q[7:4]} + {1'b0, b_q[7:4]} + {4'd0, lo_c};
    hi_adj = hi_raw + 5'd6;
    if (hi_raw > 5'd9) begin
      slice_sum[7:4] = hi_adj[3:0];
      slice_cout     = 1'b1;
    end else begin
      slice_sum[7:4] = hi_raw[3:0];
      slice_cout     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = bad_digit ? DONE : RUN;
      RUN:     if (last_pair) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, per-pair shift/accumulate, result hold.
  // Operands shift right by one digit pair per RUN cycle while the sum
  // fills in from the top, so after PAIRS cycles every pair is in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= bus.a_i;
            b_q     <= bus.b_i;
            carry_q <= bus.cin_i;
            idx_q   <= '0;
            err_q   <= bad_digit;
            if (bad_digit) begin
              sum_q  <= '0;
              cout_q <= 1'b0;
            end
          end
        end
        RUN: begin
          a_q     <= a_q >> 8;
          b_q     <= b_q >> 8;
          sum_q   <= (sum_q >> 8) | (W'(slice_sum) << (W - 8));
          carry_q <= slice_cout;
          idx_q   <= idx_q + IW'(1);
          if (last_pair) cout_q <= slice_cout;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ready_q && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy_o    = (state != IDLE);
  assign bus.sum_o     = sum_q;
  assign bus.cout_o    = cout_q;
  assign bus.err_o     = err_q;
endmodule

// File: tb/tb_bcd_seq_add_ctrl.sv
// Directed bench for bcd_seq_add_ctrl at NUM_DIGITS=8: vector table plus
// hand-written stall, mid-RUN reset and idle out_ready sequences.
module tb_bcd_seq_add_ctrl;
  localparam int ND = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bcd_seq_add_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  bcd_seq_add_ctrl #(.NUM_DIGITS(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operand set from IDLE, wait for out_valid, return result
  // and latency counted in edges starting with the accept edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       output logic [31:0] sum, output logic cout, output logic err,
                       output int lat);
    chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.a_i = a; bus.b_i = b; bus.cin_i = cin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
    sum = bus.sum_o; cout = bus.cout_o; err = bus.err_o;
  endtask

  // Consume the presented result and confirm the return to IDLE.
  task automatic consume(input logic [31:0] exp_sum);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("in_ready_rise", 64'(bus.in_ready), 64'd1);
    chk("sum_retained", 64'(bus.sum_o), 64'(exp_sum));
  endtask

  initial begin
    logic [31:0] s;
    logic        c, e;
    int          lat;

    vecs[0]  = '{32'h00000012, 32'h00000005, 1'b0, 32'h00000017, 1'b0, 1'b0, 5};
    vecs[1]  = '{32'h00000019, 32'h00000009, 1'b0, 32'h00000028, 1'b0, 1'b0, 5};
    vecs[2]  = '{32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 5};
    vecs[3]  = '{32'h00000024, 32'h00000016, 1'b1, 32'h00000041, 1'b0, 1'b0, 5};
    vecs[4]  = '{32'h99999999, 32'h99999999, 1'b1, 32'h99999999, 1'b1, 1'b0, 5};
    vecs[5]  = '{32'h0000001A, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1};
    vecs[6]  = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 5};
    vecs[7]  = '{32'h50000000, 32'h50000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 5};
    vecs[8]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 5};
    vecs[9]  = '{32'h00000000, 32'hF0000000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1};
    vecs[10] = '{32'h00000009, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 5};
    vecs[11] = '{32'h00990000, 32'h00010000, 1'b0, 32'h01000000, 1'b0, 1'b0, 5};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a_i = '0; bus.b_i = '0; bus.cin_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_sum", 64'(bus.sum_o), 64'd0);
    chk("rst_cout", 64'(bus.cout_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // Table vectors
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, e, lat);
      chk($sformatf("v%0d_sum", i), 64'(s), 64'(vecs[i].sum));
      chk($sformatf("v%0d_cout", i), 64'(c), 64'(vecs[i].cout));
      chk($sformatf("v%0d_err", i), 64'(e), 64'(vecs[i].err));
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      consume(vecs[i].sum);
    end

    // out_ready pulse while idle is ignored
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_ready_pulse_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_ready_pulse_in_ready", 64'(bus.in_ready), 64'd1);

    // Input changes during RUN, then a 10-cycle stall in DONE with in_valid high
    bus.a_i = 32'h00000012; bus.b_i = 32'h00000005; bus.cin_i = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a_i = 32'h99999999; bus.b_i = 32'h99999999; bus.cin_i = 1'b1;
    chk("run_busy", 64'(bus.busy_o), 64'd1);
    chk("run_in_ready", 64'(bus.in_ready), 64'd0);
    lat = 1;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_lat", 64'(lat), 64'd5);
    for (int k = 0; k < 10; k++) begin
      chk("stall_sum", 64'(bus.sum_o), 64'h00000017);
      chk("stall_cout_err", 64'({bus.cout_o, bus.err_o}), 64'd0);
      chk("stall_valid_ready", 64'({bus.out_valid, bus.in_ready}), 64'b10);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    consume(32'h00000017);
    do_op(32'h00000001, 32'h00000002, 1'b0, s, c, e, lat);
    chk("post_stall_sum", 64'(s), 64'h00000003);
    consume(32'h00000003);

    // Reset in the second RUN cycle aborts the operation
    bus.a_i = 32'h00000012; bus.b_i = 32'h00000005; bus.cin_i = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy", 64'(bus.busy_o), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    chk("abort_sum", 64'(bus.sum_o), 64'd0);
    chk("abort_cout_err", 64'({bus.cout_o, bus.err_o}), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("abort_never_presented", 64'(bus.out_valid), 64'd0);
    end
    do_op(32'h00000050, 32'h00000050, 1'b0, s, c, e, lat);
    chk("after_rst_sum", 64'(s), 64'h00000100);
    chk("after_rst_cout", 64'(c), 64'd0);
    chk("after_rst_lat", 64'(lat), 64'd5);
    consume(32'h00000100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
